xdiv_iter: RTL and testbench

- Memory-mapped iterative 32-bit divider peripheral.
- It sits directly downstream of the address decoder:
  - it receives its select strobe from the decoder (div_sel);
  - its combinational read data is what the decoder muxes back to the CPU as div_data_to_rd.
- Produces quotient and remainder, signed or unsigned, at one quotient bit per cycle.
- The CPU polls a status word for completion.

---
 rtl/xdiv_iter_pkg.sv | 24 ++
 rtl/xdiv_core.sv | 114 +++++++++++
 rtl/xdiv_iter.sv | 107 ++++++++++
 tb/tb_xdiv_iter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/xdiv_iter_pkg.sv
// Shared definitions for the xdiv_iter divider peripheral: address width,
// base address, register offsets and CTRL/STAT bit positions.
package xdiv_iter_pkg;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_ADDR_W = 3;

    // Base address is consumed by the upstream decoder only.
    localparam logic [31:0] DIV_BASE = 32'h0000_0100;

    localparam logic [DIV_ADDR_W-1:0] DIV_CTRL = 3'd0;
    localparam logic [DIV_ADDR_W-1:0] DIV_DVND = 3'd1;
    localparam logic [DIV_ADDR_W-1:0] DIV_DVSR = 3'd2;
    localparam logic [DIV_ADDR_W-1:0] DIV_QUOT = 3'd3;
    localparam logic [DIV_ADDR_W-1:0] DIV_REM  = 3'd4;

    localparam int CTRL_START  = 0;
    localparam int CTRL_SIGNED = 1;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_DBZ  = 2;

endpackage

// File: rtl/xdiv_core.sv
// Restoring shift/subtract divider core: one quotient bit per cycle on
// operand magnitudes, with sign fix-up applied in the final FIX cycle.
//
//   state  | meaning
//   S_IDLE | waiting for start, working registers hold last operation
//   S_CALC | one restoring step per cycle, count runs DATA_W-1 down to 0
//   S_FIX  | apply result signs; done_o pulses and q_o/r_o are valid
module xdiv_core #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] dvnd_i,
    input  logic [DATA_W-1:0] dvsr_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] q_o,
    output logic [DATA_W-1:0] r_o
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  q_q, q_d;
    logic [DATA_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0]  dvsr_q, dvsr_d;
    logic               neg_q_q, neg_q_d;
    logic               neg_r_q, neg_r_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               dvnd_neg, dvsr_neg;
    logic [DATA_W-1:0]  dvnd_mag, dvsr_mag;
    logic [DATA_W:0]    shifted, diff;

    assign dvnd_neg = signed_i & dvnd_i[DATA_W-1];
    assign dvsr_neg = signed_i & dvsr_i[DATA_W-1];
    // Negating the most negative value wraps to itself, which is the
    // correct unsigned magnitude 2^(DATA_W-1).
    assign dvnd_mag = dvnd_neg ? (~dvnd_i + 1'b1) : dvnd_i;
    assign dvsr_mag = dvsr_neg ? (~dvsr_i + 1'b1) : dvsr_i;

    assign shifted = {rem_q, q_q[DATA_W-1]};
    assign diff    = shifted - {1'b0, dvsr_q};

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        rem_d   = rem_q;
        dvsr_d  = dvsr_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    q_d     = dvnd_mag;
                    rem_d   = '0;
                    dvsr_d  = dvsr_mag;
                    neg_q_d = dvnd_neg ^ dvsr_neg;
                    neg_r_d = dvnd_neg;
                    count_d = CNT_W'(DATA_W - 1);
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (!diff[DATA_W]) begin
                    rem_d = diff[DATA_W-1:0];
                    q_d   = {q_q[DATA_W-2:0], 1'b1};
                end else begin
                    rem_d = shifted[DATA_W-1:0];
                    q_d   = {q_q[DATA_W-2:0], 1'b0};
                end
                count_d = count_q - 1'b1;
                if (count_q == '0) state_d = S_FIX;
            end
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            rem_q   <= '0;
            dvsr_q  <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            dvsr_q  <= dvsr_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            count_q <= count_d;
        end
    end

    assign busy_o = (state_q != S_IDLE);
    assign done_o = (state_q == S_FIX);
    assign q_o    = neg_q_q ? (~q_q + 1'b1) : q_q;
    assign r_o    = neg_r_q ? (~rem_q + 1'b1) : rem_q;

endmodule

// File: rtl/xdiv_iter.sv
// Memory-mapped iterative divider: register file, start/divide-by-zero
// handling and zero-latency read mux around xdiv_core.
module xdiv_iter
    import xdiv_iter_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int OFFS_W = DIV_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sel,
    input  logic              we,
    input  logic [OFFS_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              busy
);

    logic [DATA_W-1:0] dividend_q, dividend_d;
    logic [DATA_W-1:0] divisor_q, divisor_d;
    logic [DATA_W-1:0] quotient_q, quotient_d;
    logic [DATA_W-1:0] remainder_q, remainder_d;
    logic              done_q, done_d;
    logic              dbz_q, dbz_d;

    logic              wr_en, start_acc, dvsr_zero, core_start, core_done;
    logic [DATA_W-1:0] core_q, core_r;

    // All writes, including start, are locked out while a division runs.
    assign wr_en      = sel & we & ~busy;
    assign start_acc  = wr_en && (addr == OFFS_W'(DIV_CTRL)) && data_in[CTRL_START];
    assign dvsr_zero  = (divisor_q == '0);
    assign core_start = start_acc & ~dvsr_zero;

    xdiv_core #(.DATA_W(DATA_W)) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (core_start),
        .signed_i (data_in[CTRL_SIGNED]),
        .dvnd_i   (dividend_q),
        .dvsr_i   (divisor_q),
        .busy_o   (busy),
        .done_o   (core_done),
        .q_o      (core_q),
        .r_o      (core_r)
    );

    always_comb begin
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        done_d      = done_q;
        dbz_d       = dbz_q;
        if (wr_en && addr == OFFS_W'(DIV_DVND)) dividend_d = data_in;
        if (wr_en && addr == OFFS_W'(DIV_DVSR)) divisor_d  = data_in;
        if (start_acc) begin
            // Divide by zero resolves in one cycle without entering the core.
            done_d = dvsr_zero;
            dbz_d  = dvsr_zero;
            if (dvsr_zero) begin
                quotient_d  = '1;
                remainder_d = dividend_q;
            end
        end
        if (core_done) begin
            quotient_d  = core_q;
            remainder_d = core_r;
            done_d      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dividend_q  <= '0;
            divisor_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
        end
    end

    always_comb begin
        data_out = '0;
        case (addr)
            OFFS_W'(DIV_CTRL): begin
                data_out[STAT_BUSY] = busy;
                data_out[STAT_DONE] = done_q;
                data_out[STAT_DBZ]  = dbz_q;
            end
            OFFS_W'(DIV_DVND): data_out = dividend_q;
            OFFS_W'(DIV_DVSR): data_out = divisor_q;
            OFFS_W'(DIV_QUOT): data_out = quotient_q;
            OFFS_W'(DIV_REM):  data_out = remainder_q;
            default:           data_out = '0;
        endcase
    end

endmodule

// File: tb/tb_xdiv_iter.sv
// Self-checking bench for xdiv_iter: fixed vector table, randomized
// operands against an arithmetic reference, and multi-cycle corner cases.
module tb_xdiv_iter;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        busy;

    int total = 0;
    int bad   = 0;

    xdiv_iter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel      (sel),
        .we       (we),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [31:0] eq;
        logic [31:0] er;
        logic [31:0] es;
        int          ebusy;
    } vec_t;

    vec_t vecs[10];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endfunction

    // Reference: plain truncating integer division on wide signed values.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; data_in = d;
        @(negedge clk);
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = data_out;
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic sgn, output int bc);
        wr(3'd1, a);
        wr(3'd2, b);
        wr(3'd0, {30'd0, sgn, 1'b1});
        wait_idle(bc);
    endtask

    task automatic check_res(input string nm, input logic [31:0] eq, input logic [31:0] er,
                             input logic [31:0] es);
        logic [31:0] v;
        rd(3'd3, v); chk({nm, " quot"}, v, eq);
        rd(3'd4, v); chk({nm, " rem"},  v, er);
        rd(3'd0, v); chk({nm, " stat"}, v, es);
    endtask

    initial begin
        logic [31:0] v, a, b, eq, er;
        logic        sgn;
        int          bc;

        vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          32'h2, 33};
        vecs[1] = '{32'hFFFF_FF9C,  32'd7,          1'b1, 32'hFFFF_FFF2,  32'hFFFF_FFFE,  32'h2, 33};
        vecs[2] = '{32'h0000_1234,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h0000_1234,  32'h6, 0};
        vecs[3] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          32'h2, 33};
        vecs[4] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          32'h2, 33};
        vecs[5] = '{32'd7,          32'd100,        1'b0, 32'd0,          32'd7,          32'h2, 33};
        vecs[6] = '{32'd100,        32'hFFFF_FFF9,  1'b1, 32'hFFFF_FFF2,  32'd2,          32'h2, 33};
        vecs[7] = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 32'd14,         32'hFFFF_FFFE,  32'h2, 33};
        vecs[8] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,          32'd0,          32'h2, 33};
        vecs[9] = '{32'hFFFF_FF9C,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FF9C,  32'h6, 0};

        rst_n = 1'b0; sel = 1'b0; we = 1'b0; addr = 3'd0; data_in = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), v);
            chk($sformatf("reset reg%0d", i), v, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run(vecs[i].a, vecs[i].b, vecs[i].sgn, bc);
            chk($sformatf("vec%0d busy cycles", i), 32'(bc), 32'(vecs[i].ebusy));
            check_res($sformatf("vec%0d", i), vecs[i].eq, vecs[i].er, vecs[i].es);
        end

        for (int i = 0; i < 40; i++) begin
            a   = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(0, 15));
                1:       b = $urandom >> $urandom_range(0, 31);
                2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: b = $urandom;
            endcase
            sgn = 1'($urandom_range(0, 1));
            ref_div(a, b, sgn, eq, er);
            run(a, b, sgn, bc);
            chk($sformatf("rnd%0d busy cycles", i), 32'(bc), (b == 32'd0) ? 32'd0 : 32'd33);
            check_res($sformatf("rnd%0d", i), eq, er, (b == 32'd0) ? 32'h6 : 32'h2);
        end

        // Writes while busy are ignored; previous result holds until completion.
        run(32'd50, 32'd5, 1'b0, bc);
        wr(3'd1, 32'd1000);
        wr(3'd2, 32'd10);
        wr(3'd0, 32'd1);
        repeat (3) @(negedge clk);
        wr(3'd2, 32'd3);
        wr(3'd0, 32'd1);
        wr(3'd1, 32'd9);
        rd(3'd2, v); chk("busy divisor readback", v, 32'd10);
        rd(3'd1, v); chk("busy dividend readback", v, 32'd1000);
        rd(3'd3, v); chk("busy quot holds", v, 32'd10);
        rd(3'd0, v); chk("busy stat", v, 32'h1);
        wait_idle(bc);
        chk("busy prot cycles", 32'(bc), 32'd27);
        check_res("busy prot", 32'd100, 32'd0, 32'h2);

        // Asynchronous abort between clock edges.
        wr(3'd1, 32'd1000);
        wr(3'd2, 32'd10);
        wr(3'd0, 32'd1);
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), v);
            chk($sformatf("post-abort reg%0d", i), v, 32'd0);
        end
        @(negedge clk);
        run(32'd77, 32'd5, 1'b0, bc);
        chk("post-abort busy cycles", 32'(bc), 32'd33);
        check_res("post-abort", 32'd15, 32'd2, 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
